// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, optional skid entry,
// flush/halt control and saturating bubble/backpressure performance counters.
module decode_execute_stage #(
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 32,
    parameter int RD_W    = 5,
    parameter int ALUOP_W = 5,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    halted,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OPS*OP_W-1:0] operands_in,
    input  logic [RD_W-1:0]         rd_in,
    input  logic [ALUOP_W-1:0]      alu_op_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_OPS*OP_W-1:0] operands_out,
    output logic [RD_W-1:0]         rd_out,
    output logic [ALUOP_W-1:0]      alu_op_out,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        backpressure_cnt
);

    localparam int OPS_W = NUM_OPS * OP_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OPS_W-1:0]     m_ops_q, m_ops_d;
    logic [RD_W-1:0]      m_rd_q, m_rd_d;
    logic [ALUOP_W-1:0]   m_alu_q, m_alu_d;
    logic [OPS_W-1:0]     s_ops_q, s_ops_d;
    logic [RD_W-1:0]      s_rd_q, s_rd_d;
    logic [ALUOP_W-1:0]   s_alu_q, s_alu_d;
    logic [CNT_W-1:0]     bubble_q, bubble_d;
    logic [CNT_W-1:0]     bp_q, bp_d;

    logic normal;
    logic m_valid;
    logic s_valid;
    logic in_xfer;
    logic out_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign normal   = !flush && !halted;
    assign m_valid  = (state_q != ST_EMPTY);
    assign s_valid  = (state_q == ST_SKID);
    assign out_valid = m_valid && normal;

    // With the skid entry, in_ready depends only on registered state.
    always_comb begin
        in_ready = 1'b0;
        if (normal) begin
            if (SKID_EN != 0) begin
                in_ready = !s_valid;
            end else begin
                in_ready = !m_valid || out_ready;
            end
        end
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        m_ops_d  = m_ops_q;
        m_rd_d   = m_rd_q;
        m_alu_d  = m_alu_q;
        s_ops_d  = s_ops_q;
        s_rd_d   = s_rd_q;
        s_alu_d  = s_alu_q;
        bubble_d = bubble_q;
        bp_d     = bp_q;

        if (flush) begin
            state_d = ST_EMPTY;
            m_ops_d = '0;
            m_rd_d  = '0;
            m_alu_d = '0;
            s_ops_d = '0;
            s_rd_d  = '0;
            s_alu_d = '0;
        end else if (!halted) begin
            if (!m_valid) begin
                bubble_d = sat_inc(bubble_q);
            end
            if (out_valid && !out_ready) begin
                bp_d = sat_inc(bp_q);
            end

            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        m_ops_d = operands_in;
                        m_rd_d  = rd_in;
                        m_alu_d = alu_op_in;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        m_ops_d = operands_in;
                        m_rd_d  = rd_in;
                        m_alu_d = alu_op_in;
                    end else if (out_xfer) begin
                        // An emptied main entry must read as the all-zero bubble.
                        state_d = ST_EMPTY;
                        m_ops_d = '0;
                        m_rd_d  = '0;
                        m_alu_d = '0;
                    end else if (in_xfer && (SKID_EN != 0)) begin
                        state_d = ST_SKID;
                        s_ops_d = operands_in;
                        s_rd_d  = rd_in;
                        s_alu_d = alu_op_in;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                        m_ops_d = s_ops_q;
                        m_rd_d  = s_rd_q;
                        m_alu_d = s_alu_q;
                        s_ops_d = '0;
                        s_rd_d  = '0;
                        s_alu_d = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            m_ops_q  <= '0;
            m_rd_q   <= '0;
            m_alu_q  <= '0;
            s_ops_q  <= '0;
            s_rd_q   <= '0;
            s_alu_q  <= '0;
            bubble_q <= '0;
            bp_q     <= '0;
        end else begin
            state_q  <= state_d;
            m_ops_q  <= m_ops_d;
            m_rd_q   <= m_rd_d;
            m_alu_q  <= m_alu_d;
            s_ops_q  <= s_ops_d;
            s_rd_q   <= s_rd_d;
            s_alu_q  <= s_alu_d;
            bubble_q <= bubble_d;
            bp_q     <= bp_d;
        end
    end

    assign operands_out     = m_ops_q;
    assign rd_out           = m_rd_q;
    assign alu_op_out       = m_alu_q;
    assign bubble_cnt       = bubble_q;
    assign backpressure_cnt = bp_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: default skid config, a CNT_W=4 instance for
// saturation and a SKID_EN=0 instance, all sharing one input stream.
module tb_decode_execute_stage;

    logic        clk = 1'b0;
    logic        reset, flush, halted, in_valid, out_ready;
    logic [63:0] operands_in;
    logic [4:0]  rd_in, alu_op_in;

    logic        in_ready_a, out_valid_a;
    logic [63:0] ops_a;
    logic [4:0]  rd_a, alu_a;
    logic [15:0] bub_a, bp_a;

    logic        in_ready_b, out_valid_b;
    logic [63:0] ops_b;
    logic [4:0]  rd_b, alu_b;
    logic [3:0]  bub_b, bp_b;

    logic        in_ready_c, out_valid_c;
    logic [63:0] ops_c;
    logic [4:0]  rd_c, alu_c;
    logic [15:0] bub_c, bp_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_execute_stage dut_a (
        .clk(clk), .reset(reset), .flush(flush), .halted(halted),
        .in_valid(in_valid), .in_ready(in_ready_a), .operands_in(operands_in),
        .rd_in(rd_in), .alu_op_in(alu_op_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .operands_out(ops_a), .rd_out(rd_a),
        .alu_op_out(alu_a), .bubble_cnt(bub_a), .backpressure_cnt(bp_a)
    );

    decode_execute_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .halted(halted),
        .in_valid(in_valid), .in_ready(in_ready_b), .operands_in(operands_in),
        .rd_in(rd_in), .alu_op_in(alu_op_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .operands_out(ops_b), .rd_out(rd_b),
        .alu_op_out(alu_b), .bubble_cnt(bub_b), .backpressure_cnt(bp_b)
    );

    decode_execute_stage #(.SKID_EN(0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .halted(halted),
        .in_valid(in_valid), .in_ready(in_ready_c), .operands_in(operands_in),
        .rd_in(rd_in), .alu_op_in(alu_op_in), .out_valid(out_valid_c),
        .out_ready(out_ready), .operands_out(ops_c), .rd_out(rd_c),
        .alu_op_out(alu_c), .bubble_cnt(bub_c), .backpressure_cnt(bp_c)
    );

    typedef struct {
        int iv; int ordy; int fl; int rd;
        int eir; int eov; int erd; int ebub; int ebp;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [63:0] mk_ops(input logic [4:0] r);
        return {32'hA000_0000 | {27'd0, r}, 32'hB000_0000 | {27'd0, r}};
    endfunction

    function automatic logic [4:0] mk_alu(input logic [4:0] r);
        return ~r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic hl,
                         input logic [4:0] r);
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        halted      = hl;
        rd_in       = r;
        operands_in = mk_ops(r);
        alu_op_in   = mk_alu(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int exp_out;
        int nout;
        logic orr;

        // iv ordy fl rd | in_ready out_valid rd_out bubble backpressure
        tbl[0]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 2, 1, 1, 1, 1, 0};
        tbl[2]  = '{1, 1, 0, 3, 1, 1, 2, 1, 0};
        tbl[3]  = '{1, 1, 0, 4, 1, 1, 3, 1, 0};
        tbl[4]  = '{1, 1, 0, 5, 1, 1, 4, 1, 0};
        tbl[5]  = '{1, 1, 0, 6, 1, 1, 5, 1, 0};
        tbl[6]  = '{1, 1, 0, 7, 1, 1, 6, 1, 0};
        tbl[7]  = '{1, 1, 0, 8, 1, 1, 7, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 1, 8, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 0, 2, 1, 1, 1, 2, 0};
        tbl[11] = '{1, 0, 0, 3, 0, 1, 1, 2, 1};
        tbl[12] = '{1, 0, 0, 3, 0, 1, 1, 2, 2};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 1, 2, 3};
        tbl[14] = '{0, 1, 0, 0, 1, 1, 2, 2, 3};
        tbl[15] = '{0, 1, 0, 0, 1, 0, 0, 2, 3};
        tbl[16] = '{1, 0, 0, 4, 1, 0, 0, 3, 3};
        tbl[17] = '{1, 0, 0, 5, 1, 1, 4, 4, 3};
        tbl[18] = '{1, 0, 1, 6, 0, 0, 4, 4, 4};
        tbl[19] = '{0, 1, 0, 0, 1, 0, 0, 4, 4};
        tbl[20] = '{0, 1, 0, 0, 1, 0, 0, 5, 4};

        // Reset state
        do_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_operands", ops_a, 64'd0);
        chk("rst_rd", 64'(rd_a), 64'd0);
        chk("rst_alu_op", 64'(alu_a), 64'd0);
        chk("rst_bubble", 64'(bub_a), 64'd0);
        chk("rst_backpressure", 64'(bp_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_in_ready_noskid", 64'(in_ready_c), 64'd1);
        tick();

        // Streaming, backpressure and flush-in-skid vectors
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].iv != 0, tbl[i].ordy != 0, tbl[i].fl != 0, 1'b0, 5'(tbl[i].rd));
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready_a), 64'(tbl[i].eir));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid_a), 64'(tbl[i].eov));
            chk($sformatf("v%0d_rd_out", i), 64'(rd_a), 64'(tbl[i].erd));
            chk($sformatf("v%0d_operands", i), ops_a,
                (tbl[i].erd == 0) ? 64'd0 : mk_ops(5'(tbl[i].erd)));
            chk($sformatf("v%0d_alu_op", i), 64'(alu_a),
                (tbl[i].erd == 0) ? 64'd0 : 64'(mk_alu(5'(tbl[i].erd))));
            chk($sformatf("v%0d_bubble", i), 64'(bub_a), 64'(tbl[i].ebub));
            chk($sformatf("v%0d_backpressure", i), 64'(bp_a), 64'(tbl[i].ebp));
            tick();
        end

        // Halt with a loaded payload, then halt while empty, then flush while halted
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
        operands_in = 64'hDEADBEEF_12345678;
        alu_op_in   = 5'd3;
        #1;
        chk("halt_load_in_ready", 64'(in_ready_a), 64'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9);
            #1;
            chk($sformatf("halt%0d_in_ready", k), 64'(in_ready_a), 64'd0);
            chk($sformatf("halt%0d_out_valid", k), 64'(out_valid_a), 64'd0);
            chk($sformatf("halt%0d_operands", k), ops_a, 64'hDEADBEEF_12345678);
            chk($sformatf("halt%0d_rd", k), 64'(rd_a), 64'd7);
            chk($sformatf("halt%0d_alu_op", k), 64'(alu_a), 64'd3);
            chk($sformatf("halt%0d_bubble", k), 64'(bub_a), 64'd1);
            chk($sformatf("halt%0d_backpressure", k), 64'(bp_a), 64'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("release_out_valid", 64'(out_valid_a), 64'd1);
        chk("release_operands", ops_a, 64'hDEADBEEF_12345678);
        chk("release_rd", 64'(rd_a), 64'd7);
        chk("release_alu_op", 64'(alu_a), 64'd3);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("release_backpressure", 64'(bp_a), 64'd1);
        chk("release_drain_valid", 64'(out_valid_a), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
            #1;
            chk($sformatf("halt_empty%0d_bubble", k), 64'(bub_a), 64'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("halt_empty_after_bubble", 64'(bub_a), 64'd1);
        chk("halt_empty_after_valid", 64'(out_valid_a), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd10);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd11);
        #1;
        chk("halt_flush_in_ready", 64'(in_ready_a), 64'd0);
        chk("halt_flush_out_valid", 64'(out_valid_a), 64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("post_halt_flush_valid", 64'(out_valid_a), 64'd0);
        chk("post_halt_flush_rd", 64'(rd_a), 64'd0);
        chk("post_halt_flush_operands", ops_a, 64'd0);
        chk("post_halt_flush_alu_op", 64'(alu_a), 64'd0);
        chk("post_halt_flush_in_ready", 64'(in_ready_a), 64'd1);
        chk("post_halt_flush_bubble", 64'(bub_a), 64'd2);

        // Reset mid-stream from the skid state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd12);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd13);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid_a), 64'd0);
        chk("midrst_rd", 64'(rd_a), 64'd0);
        chk("midrst_operands", ops_a, 64'd0);
        chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("midrst_bubble", 64'(bub_a), 64'd0);
        chk("midrst_backpressure", 64'(bp_a), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        #1;
        chk("midrst_no_leftover", 64'(out_valid_a), 64'd0);

        // Counter saturation on the CNT_W=4 instance
        do_reset();
        repeat (20) tick();
        chk("sat_bubble_4bit", 64'(bub_b), 64'd15);
        chk("sat_bubble_16bit", 64'(bub_a), 64'd20);
        do_reset();
        #1;
        chk("sat_reset_bubble", 64'(bub_b), 64'd0);
        repeat (3) tick();
        chk("sat_restart_bubble", 64'(bub_b), 64'd3);

        // SKID_EN=0: full-rate input with out_ready toggling
        do_reset();
        nxt = 1;
        exp_out = 1;
        nout = 0;
        for (int c = 0; c < 20; c++) begin
            orr = (c % 2) == 1;
            drive(1'b1, orr, 1'b0, 1'b0, 5'(nxt));
            #1;
            chk($sformatf("ns%0d_in_ready", c), 64'(in_ready_c), 64'(!out_valid_c || orr));
            if (out_valid_c && orr) begin
                chk($sformatf("ns%0d_order", c), 64'(rd_c), 64'(exp_out));
                exp_out++;
                nout++;
            end
            if (in_ready_c) nxt++;
            tick();
        end
        chk("ns_output_count", 64'(nout), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_execute_stage.md
# decode_execute_stage

Parametrised pipeline register between decode and execute, generalised with a valid/ready handshake, an optional skid entry, a configurable operand count and width, and performance counters. It carries the operands, the destination register and the ALU opcode from decode to execute. It supports flush (squash) and halt (freeze). When the stage is empty, its output payload is the all-zero bubble, so execute sees rd = 0 / alu_op = 0 for NOPs.

## Interface
- NUM_OPS, default 2: number of operand lanes.
- OP_W, default 32: width of each operand.
- RD_W, default 5: destination register index width.
- ALUOP_W, default 5: ALU opcode width.
- SKID_EN, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, default 16: performance counter width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: squash all held entries this cycle.
- halted, input, 1: freeze all state; no transfers.
- in_valid, input, 1: decode presents a payload.
- in_ready, output, 1: the stage can accept a payload.
- operands_in, input, NUM_OPS*OP_W: operand lanes; lane i is bits [i*OP_W +: OP_W].
- rd_in, input, RD_W: destination register.
- alu_op_in, input, ALUOP_W: ALU opcode.
- out_valid, output, 1: execute payload valid.
- out_ready, input, 1: execute consumes the payload.
- operands_out, output, NUM_OPS*OP_W: registered operands.
- rd_out, output, RD_W: registered destination register.
- alu_op_out, output, ALUOP_W: registered opcode.
- bubble_cnt, output, CNT_W: count of cycles the stage was empty.
- backpressure_cnt, output, CNT_W: count of cycles out_valid was high while out_ready was low.

## Operation
- Storage:
  - The main entry (M) drives the outputs.
  - The skid entry (S) exists only when SKID_EN = 1.
  - Each entry has a valid bit and holds operands, rd and alu_op.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Priority per cycle: reset > flush > halted > normal.
  - reset: M and S are invalidated and their payloads zeroed; both counters are cleared.
  - flush: M and S are invalidated and their payloads zeroed. Counters are unaffected. A flush is honoured even while halted.
  - halted (no flush): M, S and the counters hold their values.
- Derived outputs:
  - out_valid = M.valid && !halted && !flush.
  - in_ready = 0 whenever flush or halted is asserted.
  - Otherwise, SKID_EN = 1: in_ready = !S.valid (registered state, no combinational path from out_ready).
  - Otherwise, SKID_EN = 0: in_ready = !M.valid || out_ready.
- Payload rule: operands_out, rd_out and alu_op_out always show M's payload. M's payload is zeroed whenever M becomes invalid, so an empty stage emits the all-zero bubble. While halted, out_valid is 0 but the payload holds.
- State machine for SKID_EN = 1 (normal cycles only):
  - EMPTY (M invalid, S invalid):
    - Input transfer → FULL, with M loaded.
  - FULL (M valid, S invalid):
    - Input and output transfer → FULL, with M reloaded from the input.
    - Output transfer only → EMPTY, with M zeroed.
    - Input transfer only → SKID, with S loaded.
  - SKID (M valid, S valid; in_ready = 0):
    - Output transfer → FULL, with M ← S and S zeroed.
    - Otherwise hold.
- Ordering: payloads leave in arrival order. No payload is ever duplicated or dropped, except by reset or flush.
- For SKID_EN = 0, only EMPTY and FULL exist, with the same transitions; SKID is unreachable.
- Counters:
  - bubble_cnt increments on a normal cycle (no reset, flush or halted) when M is invalid.
  - backpressure_cnt increments on a normal cycle when out_valid && !out_ready.
  - Both counters saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- Latency is 1 cycle: a payload accepted at edge N is presented on out_valid after edge N.
- Throughput is 1 payload per cycle with out_ready held high, in both modes.
- Reset values:
  - out_valid = 0.
  - operands_out, rd_out, alu_op_out = 0.
  - bubble_cnt = backpressure_cnt = 0.
  - in_ready = 1 on the first cycle after reset, unless halted or flush is asserted.
- Simultaneous flush and in_valid: the input is not accepted (in_ready = 0) and the stage is empty after the edge.
- Flush in the SKID state: both entries are discarded in one cycle.
- Reset mid-stream: all in-flight payloads are lost, and the counters restart from 0.
- Halt release: out_valid reappears in the same cycle halted drops, showing the pre-halt payload.

## Test plan
- **Streaming:** reset, then 8 back-to-back payloads (rd = 1..8) with out_ready = 1.
  - First out_valid appears 1 cycle after the first accept.
  - Outputs rd_out = 1..8 on consecutive cycles.
  - bubble_cnt = 1, backpressure_cnt = 0.
- **Backpressure (SKID_EN = 1):** hold out_ready = 0 while sending 3 payloads.
  - Exactly 2 are accepted; in_ready = 0 after the second accept.
  - After out_ready = 1, rd_out shows 1 then 2, in order, with no loss.
  - backpressure_cnt equals the number of stalled cycles.
- **Flush:** in the SKID state, assert flush together with in_valid.
  - Next cycle: out_valid = 0, operands_out = 0, rd_out = 0, alu_op_out = 0, in_ready = 1.
  - The flushed input never appears on the output.
- **Halt:** with M holding operands = {0xDEADBEEF, 0x12345678}, assert halted for 5 cycles while driving in_valid = 1.
  - in_ready = 0 and out_valid = 0 throughout; the payload is unchanged; both counters are frozen.
  - On release, out_valid = 1 with the same payload.
- **Saturation:** with CNT_W = 4, leave the stage empty for 20 cycles.
  - bubble_cnt stops at 15.
  - A reset mid-run returns bubble_cnt to 0.
- **SKID_EN = 0:** at full throughput with out_ready toggling every cycle, confirm in_ready == (!M.valid || out_ready) each cycle and that output order is preserved.
